// File: rtl/video_mask_gen.sv
// Synthetic video timing source with a programmable rectangular mask.
// Rectangle updates are double-buffered and only applied at the frame boundary.
module video_mask_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ce_i,
    input  logic [10:0] rect_x0_i,
    input  logic [10:0] rect_x1_i,
    input  logic [9:0]  rect_y0_i,
    input  logic [9:0]  rect_y1_i,
    input  logic        rect_valid_i,
    output logic        rect_ready_o,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        mask_o,
    output logic [10:0] x_cnt_o,
    output logic [9:0]  y_cnt_o,
    output logic        sof_o,
    output logic [15:0] frame_cnt_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] HLast     = 11'(H_TOTAL - 1);
    localparam logic [10:0] HActEnd   = 11'(H_ACTIVE);
    localparam logic [10:0] HSyncBeg  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HSyncEnd  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VLast     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VActEnd   = 10'(V_ACTIVE);
    localparam logic [9:0]  VSyncBeg  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VSyncEnd  = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Raster counters
    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        h_last, v_last, frame_end;

    assign h_last    = (h_q == HLast);
    assign v_last    = (v_q == VLast);
    assign frame_end = h_last && v_last;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (ce_i) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Pending / active rectangle
    logic [10:0] pend_x0_q, pend_x1_q, act_x0_q, act_x1_q;
    logic [9:0]  pend_y0_q, pend_y1_q, act_y0_q, act_y1_q;
    logic        pend_vld_q, pend_vld_d;
    logic        act_en_q;
    logic        accept, apply;

    // accept and apply are exclusive: a rectangle taken in the boundary cycle waits a frame
    assign accept       = rect_valid_i && !pend_vld_q;
    assign apply        = ce_i && frame_end && pend_vld_q;
    assign rect_ready_o = !pend_vld_q;

    always_comb begin
        pend_vld_d = pend_vld_q;
        if (apply) begin
            pend_vld_d = 1'b0;
        end else if (accept) begin
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_vld_q <= 1'b0;
            pend_x0_q  <= '0;
            pend_x1_q  <= '0;
            pend_y0_q  <= '0;
            pend_y1_q  <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            if (accept) begin
                pend_x0_q <= rect_x0_i;
                pend_x1_q <= rect_x1_i;
                pend_y0_q <= rect_y0_i;
                pend_y1_q <= rect_y1_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_en_q <= 1'b0;
            act_x0_q <= '0;
            act_x1_q <= '0;
            act_y0_q <= '0;
            act_y1_q <= '0;
        end else if (apply) begin
            act_en_q <= 1'b1;
            act_x0_q <= pend_x0_q;
            act_x1_q <= pend_x1_q;
            act_y0_q <= pend_y0_q;
            act_y1_q <= pend_y1_q;
        end
    end

    // Decode of the current counter position
    logic de_d, hsync_d, vsync_d, mask_d, sof_d;
    logic in_x, in_y;

    always_comb begin
        de_d    = (h_q < HActEnd) && (v_q < VActEnd);
        hsync_d = (h_q >= HSyncBeg) && (h_q < HSyncEnd);
        vsync_d = (v_q >= VSyncBeg) && (v_q < VSyncEnd);
        sof_d   = (h_q == '0) && (v_q == '0);
        in_x    = (h_q >= act_x0_q) && (h_q <= act_x1_q);
        in_y    = (v_q >= act_y0_q) && (v_q <= act_y1_q);
        mask_d  = de_d && act_en_q && in_x && in_y;
    end

    logic        de_q, hsync_q, vsync_q, mask_q, sof_q;
    logic [10:0] x_cnt_q;
    logic [9:0]  y_cnt_q;
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            de_q        <= 1'b0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            mask_q      <= 1'b0;
            sof_q       <= 1'b0;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            frame_cnt_q <= '0;
        end else if (ce_i) begin
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            mask_q  <= mask_d;
            sof_q   <= sof_d;
            x_cnt_q <= h_q;
            y_cnt_q <= v_q;
            if (frame_end) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign de_o        = de_q;
    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;
    assign mask_o      = mask_q;
    assign sof_o       = sof_q;
    assign x_cnt_o     = x_cnt_q;
    assign y_cnt_o     = y_cnt_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_video_mask_gen.sv
// Scoreboard bench for video_mask_gen on a reduced raster (25x15 clocks per frame).
module tb_video_mask_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 4, HT = HA + HF + HS + HB;
    localparam int VA = 10, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ce_i;
    logic [10:0] rect_x0_i, rect_x1_i;
    logic [9:0]  rect_y0_i, rect_y1_i;
    logic        rect_valid_i;
    logic        rect_ready_o, de_o, hsync_o, vsync_o, mask_o, sof_o;
    logic [10:0] x_cnt_o;
    logic [9:0]  y_cnt_o;
    logic [15:0] frame_cnt_o;

    video_mask_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .ce_i        (ce_i),
        .rect_x0_i   (rect_x0_i),
        .rect_x1_i   (rect_x1_i),
        .rect_y0_i   (rect_y0_i),
        .rect_y1_i   (rect_y1_i),
        .rect_valid_i(rect_valid_i),
        .rect_ready_o(rect_ready_o),
        .de_o        (de_o),
        .hsync_o     (hsync_o),
        .vsync_o     (vsync_o),
        .mask_o      (mask_o),
        .x_cnt_o     (x_cnt_o),
        .y_cnt_o     (y_cnt_o),
        .sof_o       (sof_o),
        .frame_cnt_o (frame_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        sof;
        logic        mask;
        logic [10:0] x;
        logic [9:0]  y;
    } exp_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model state
    int   m_h, m_v, m_frame;
    bit   m_pend, m_act;
    int   p_x0, p_x1, p_y0, p_y1, a_x0, a_x1, a_y0, a_y1;
    exp_t exp_q[$];
    exp_t last_exp;
    int   last_frame;

    // Per-frame statistics taken from DUT outputs, snapshotted at each sof rise
    int c_de, c_hs, c_vs, c_mask, c_len;
    int f_de, f_hs, f_vs, f_mask, f_len;
    int n_sof;
    bit sof_prev;

    function automatic exp_t decode(input int h, input int v);
        exp_t e;
        e.de   = (h < HA) && (v < VA);
        e.hs   = (h >= HA + HF) && (h < HA + HF + HS);
        e.vs   = (v >= VA + VF) && (v < VA + VF + VS);
        e.sof  = (h == 0) && (v == 0);
        e.mask = e.de && m_act && (h >= a_x0) && (h <= a_x1) && (v >= a_y0) && (v <= a_y1);
        e.x    = 11'(h);
        e.y    = 10'(v);
        return e;
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_frame = 0; m_pend = 0; m_act = 0;
        a_x0 = 0; a_x1 = 0; a_y0 = 0; a_y1 = 0;
        exp_q.delete();
        last_exp = '0;
        last_frame = 0;
        c_de = 0; c_hs = 0; c_vs = 0; c_mask = 0; c_len = 0;
        sof_prev = 0;
    endtask

    task automatic check_outputs();
        check_eq("timing", {last_exp.de, last_exp.hs, last_exp.vs, last_exp.sof,
                            last_exp.x, last_exp.y},
                 {de_o, hsync_o, vsync_o, sof_o, x_cnt_o, y_cnt_o});
        check_eq("mask", mask_o, last_exp.mask);
        check_eq("frame_cnt", frame_cnt_o, last_frame);
        check_eq("rect_ready", rect_ready_o, !m_pend);
    endtask

    task automatic tick();
        exp_t e;
        bit   wrap;
        e = '0;
        wrap = ce_i && (m_h == HT - 1) && (m_v == VT - 1);
        if (ce_i) e = decode(m_h, m_v);
        if (m_pend && wrap) begin
            a_x0 = p_x0; a_x1 = p_x1; a_y0 = p_y0; a_y1 = p_y1;
            m_act = 1; m_pend = 0;
        end else if (!m_pend && rect_valid_i) begin
            p_x0 = rect_x0_i; p_x1 = rect_x1_i; p_y0 = rect_y0_i; p_y1 = rect_y1_i;
            m_pend = 1;
        end
        if (ce_i) begin
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h++;
            end
            if (wrap) m_frame = (m_frame + 1) % 65536;
            exp_q.push_back(e);
        end
        @(posedge clk_i);
        #1;
        if (ce_i) begin
            last_exp   = exp_q.pop_front();
            last_frame = m_frame;
        end
        check_outputs();
        if (sof_o && !sof_prev) begin
            f_de = c_de; f_hs = c_hs; f_vs = c_vs; f_mask = c_mask; f_len = c_len;
            c_de = 0; c_hs = 0; c_vs = 0; c_mask = 0; c_len = 0;
            n_sof++;
        end
        c_len++;
        c_de += int'(de_o); c_hs += int'(hsync_o); c_vs += int'(vsync_o);
        c_mask += int'(mask_o);
        sof_prev = sof_o;
    endtask

    task automatic run_sofs(input int n, input bit toggle);
        int start;
        int k;
        start = n_sof;
        k = 0;
        while (n_sof < start + n && k < 2 * FRAME * (n + 1)) begin
            ce_i = toggle ? !ce_i : 1'b1;
            tick();
            k++;
        end
        if (n_sof < start + n) check_eq("sof_timeout", n_sof, start + n);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ce_i = 1'b1;
            tick();
        end
    endtask

    task automatic offer(input int x0, input int x1, input int y0, input int y1);
        rect_x0_i = 11'(x0); rect_x1_i = 11'(x1);
        rect_y0_i = 10'(y0); rect_y1_i = 10'(y1);
        rect_valid_i = 1'b1;
        ce_i = 1'b1;
        tick();
        rect_valid_i = 1'b0;
    endtask

    task automatic check_frame(input int de, input int hs, input int vs, input int len,
                               input int mask);
        check_eq("f_de", f_de, de);
        check_eq("f_hsync", f_hs, hs);
        check_eq("f_vsync", f_vs, vs);
        check_eq("f_period", f_len, len);
        check_eq("f_mask", f_mask, mask);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk_i);
        #1;
        check_outputs();
        rst_ni = 1'b1;
    endtask

    initial begin
        int k;
        rst_ni = 1'b0; ce_i = 1'b0; rect_valid_i = 1'b0;
        rect_x0_i = '0; rect_x1_i = '0; rect_y0_i = '0; rect_y1_i = '0;
        n_sof = 0;
        f_de = 0; f_hs = 0; f_vs = 0; f_mask = 0; f_len = 0;
        p_x0 = 0; p_x1 = 0; p_y0 = 0; p_y1 = 0;
        do_reset();

        // First ce cycle after reset shows pixel (0,0) with no rectangle applied
        ce_i = 1'b1;
        tick();
        check_eq("first_pix", {sof_o, de_o, mask_o}, 3'b110);
        run_sofs(1, 1'b0);
        check_frame(HA * VA, HS * VT, VS * HT, FRAME, 0);

        // Rectangle 2..5 x 3..6 offered mid-frame
        run_ticks(100);
        offer(2, 5, 3, 6);
        check_eq("ready_drop", rect_ready_o, 1'b0);
        run_sofs(1, 1'b0);
        check_eq("mask_same_frame", f_mask, 0);
        run_sofs(1, 1'b0);
        check_frame(HA * VA, HS * VT, VS * HT, FRAME, 16);

        // Reversed x range yields an empty mask
        run_ticks(60);
        offer(10, 5, 0, 9);
        run_sofs(1, 1'b0);
        check_eq("mask_old_rect", f_mask, 16);
        run_sofs(1, 1'b0);
        check_frame(HA * VA, HS * VT, VS * HT, FRAME, 0);

        // Offer exactly in the frame-boundary cycle
        k = 0;
        while (!(m_h == HT - 1 && m_v == VT - 1) && k < 2 * FRAME) begin
            run_ticks(1);
            k++;
        end
        if (k >= 2 * FRAME) check_eq("boundary_timeout", k, 0);
        offer(0, HA - 1, 0, VA - 1);
        run_sofs(1, 1'b0);
        check_eq("ready_after_bnd", rect_ready_o, 1'b0);
        run_sofs(1, 1'b0);
        check_eq("mask_not_applied", f_mask, 0);
        run_sofs(1, 1'b0);
        check_eq("mask_applied_next", f_mask, HA * VA);

        // ce alternating: all widths double in clock cycles
        run_sofs(1, 1'b1);
        run_sofs(1, 1'b1);
        check_frame(2 * HA * VA, 2 * HS * VT, 2 * VS * HT, 2 * FRAME, 2 * HA * VA);

        // Reset mid-frame with a rectangle pending and frame_cnt = 7
        ce_i = 1'b1;
        tick();
        do_reset();
        k = 0;
        while (m_frame != 7 && k < 8 * FRAME) begin
            run_ticks(1);
            k++;
        end
        run_ticks(50);
        offer(2, 5, 3, 6);
        run_ticks(20);
        check_eq("pre_rst_frame", frame_cnt_o, 16'd7);
        check_eq("pre_rst_pend", rect_ready_o, 1'b0);
        do_reset();
        ce_i = 1'b1;
        tick();
        check_eq("rst_first_pix", {sof_o, de_o, mask_o, frame_cnt_o}, {3'b110, 16'd0});
        run_sofs(1, 1'b0);
        check_eq("rst_frame_mask", f_mask, 0);
        run_sofs(1, 1'b0);
        check_eq("rst_next_mask", f_mask, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
